// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID queue: reset level, bubble word and the
// default bus widths of the instruction address and instruction word.
package if_id_queue_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam logic [InstBus-1:0] ZeroWord = '0;

    // Occupancy condition of the queue, derived from the count register.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x WIDTH register array: synchronous write port, combinational read port.
module if_id_queue_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage has no reset; only entries covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head entry is visible in the same cycle its address is presented.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID queue: DEPTH-entry FIFO of {pc, inst} pairs between fetch and decode,
// valid/ready on both sides, synchronous flush, zero bubble when empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned  ADDR_W = InstAddrBus,
    parameter int unsigned  INST_W = InstBus,
    parameter int unsigned  DEPTH  = 4,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              id_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned WIDTH = ADDR_W + INST_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    occ_e             occ;

    // Handshake decode; flush suppresses both transfers in its cycle.
    always_comb begin
        if_ready = (count != CNT_FULL);
        id_valid = (count != '0);
        push     = if_valid & if_ready & ~flush;
        pop      = id_valid & id_ready & ~flush;
    end

    // Occupancy condition, for readability of the count transitions.
    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == CNT_FULL) begin
            occ = OCC_FULL;
        end
    end

    // Pointer and count registers; flush returns to empty with zeroed pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop && occ != OCC_FULL) begin
                count <= count + 1'b1;
            end else if (pop && !push && occ != OCC_EMPTY) begin
                count <= count - 1'b1;
            end
        end
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({if_pc, if_inst}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head entry gated to an all-zero bubble whenever the queue is empty.
    always_comb begin
        id_pc   = '0;
        id_inst = ZeroWord[INST_W-1:0];
        if (id_valid) begin
            id_pc   = head[WIDTH-1:INST_W];
            id_inst = head[INST_W-1:0];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: an in-order scoreboard tracks every
// accepted instruction and checks occupancy, handshakes and head contents.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    bit seen_40  = 1'b0;

    logic [63:0] exp_q[$];

    if_id_queue #(
        .ADDR_W (32),
        .INST_W (32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'hA5C3} ^ 32'h0F0F_0000;
    endfunction

    // Scoreboard: inputs are stable at the falling edge and apply at the next rising edge.
    always @(negedge clk) begin
        logic        push_m;
        logic        pop_m;
        logic [63:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (id_valid === 1'b1 && id_pc === 32'h40) seen_40 = 1'b1;
            n_checks++;
            if (count !== 3'(exp_q.size())) begin
                n_fail++;
                $display("FAIL sb_count: got %0d expected %0d at %0t", count, exp_q.size(), $time);
            end
            n_checks++;
            if (id_valid !== (exp_q.size() != 0)) begin
                n_fail++;
                $display("FAIL sb_id_valid: got %b expected %b at %0t", id_valid, exp_q.size() != 0, $time);
            end
            n_checks++;
            if (if_ready !== (exp_q.size() != DEPTH)) begin
                n_fail++;
                $display("FAIL sb_if_ready: got %b expected %b at %0t", if_ready, exp_q.size() != DEPTH, $time);
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                if (id_pc !== 32'h0 || id_inst !== 32'h0) begin
                    n_fail++;
                    $display("FAIL sb_bubble: got pc=%h inst=%h expected zeros at %0t", id_pc, id_inst, $time);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                push_m = if_valid && (exp_q.size() != DEPTH);
                pop_m  = id_ready && (exp_q.size() != 0);
                if (pop_m) begin
                    e = exp_q.pop_front();
                    n_pops++;
                    n_checks++;
                    if ({id_pc, id_inst} !== e) begin
                        n_fail++;
                        $display("FAIL sb_head: got pc=%h inst=%h expected pc=%h inst=%h at %0t",
                                 id_pc, id_inst, e[63:32], e[31:0], $time);
                    end
                end
                if (push_m) exp_q.push_back({if_pc, if_inst});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst_of(pc);
    endtask

    task automatic drain();
        int unsigned k;
        id_ready = 1'b1;
        if_valid = 1'b0;
        for (k = 0; k < 12 && count != 0; k++) cyc();
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_timeout: got count=%0d expected 0", count);
        end
        id_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_during: got v=%b r=%b c=%0d expected 0 1 0", id_valid, if_ready, count);
        end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || if_ready !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b pc=%h inst=%h r=%b c=%0d", id_valid, id_pc, id_inst, if_ready, count);
        end
    endtask

    task automatic test_single();
        if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h3401_1234; id_ready = 1'b1;
        cyc();
        if_valid = 1'b0;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'h3401_1234) begin
            n_fail++;
            $display("FAIL single_head: got v=%b pc=%h inst=%h expected 1 00000100 34011234", id_valid, id_pc, id_inst);
        end
        cyc();
        n_checks++;
        if (count !== 3'd0 || id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: got c=%0d v=%b expected 0 0", count, id_valid);
        end
        id_ready = 1'b0;
    endtask

    task automatic test_fill();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(32'(i * 4));
            cyc();
        end
        offer(32'h10);
        cyc();
        n_checks++;
        if (count !== 3'd4 || if_ready !== 1'b0 || id_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL fill_full: got c=%0d r=%b pc=%h expected 4 0 00000000", count, if_ready, id_pc);
        end
    endtask

    task automatic test_full_pop();
        offer(32'h10);
        id_ready = 1'b1;
        cyc();
        n_checks++;
        if (if_ready !== 1'b1 || id_pc !== 32'h4 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL full_pop_ready: got r=%b pc=%h c=%0d expected 1 00000004 3", if_ready, id_pc, count);
        end
        cyc();
        if_valid = 1'b0;
        n_checks++;
        if (id_pc !== 32'h8 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL full_pop_wrap: got pc=%h c=%0d expected 00000008 3", id_pc, count);
        end
        drain();
    endtask

    task automatic test_stream();
        int pops0;
        pops0 = n_pops;
        id_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer(32'h200 + 32'(i * 4));
            cyc();
            n_checks++;
            if (count !== 3'd1 || id_pc !== 32'h200 + 32'(i * 4)) begin
                n_fail++;
                $display("FAIL stream_%0d: got c=%0d pc=%h expected 1 %h", i, count, id_pc, 32'h200 + 32'(i * 4));
            end
        end
        drain();
        n_checks++;
        if (n_pops - pops0 != 20) begin
            n_fail++;
            $display("FAIL stream_pops: got %0d expected 20", n_pops - pops0);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h20 + 32'(i * 4));
            cyc();
        end
        n_checks++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_pre: got c=%0d expected 3", count);
        end
        flush = 1'b1;
        offer(32'h40);
        id_ready = 1'b1;
        cyc();
        flush = 1'b0;
        if_valid = 1'b0;
        n_checks++;
        if (count !== 3'd0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_clear: got c=%0d v=%b pc=%h expected 0 0 00000000", count, id_valid, id_pc);
        end
        id_ready = 1'b0;
        offer(32'h80);
        cyc();
        if_valid = 1'b0;
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h80) begin
            n_fail++;
            $display("FAIL flush_after: got v=%b pc=%h expected 1 00000080", id_valid, id_pc);
        end
        drain();
        n_checks++;
        if (seen_40) begin
            n_fail++;
            $display("FAIL flush_discard: got pc 00000040 at head expected never");
        end
    endtask

    task automatic test_async_reset();
        id_ready = 1'b0;
        offer(32'h300);
        cyc();
        offer(32'h304);
        cyc();
        if_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got c=%0d v=%b r=%b expected 0 0 1", count, id_valid, if_ready);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_stream();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of {pc, inst} pairs between the fetch and decode stages.
- Replaces the stall-vector handshake with valid/ready handshakes on both sides.
- Adds a synchronous flush for branch redirects.
- Presents an explicit zero-word bubble to decode whenever the queue is empty.

Parameters:
- ADDR_W, 32, width of the instruction address (pc).
- INST_W, 32, width of the instruction word.
- DEPTH, 4, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all queued entries (branch or jump redirect).
- if_valid  in  1  fetch offers an instruction this cycle.
- if_pc  in  ADDR_W  pc of the offered instruction.
- if_inst  in  INST_W  offered instruction.
- if_ready  out  1  queue accepts an instruction this cycle.
- id_valid  out  1  head entry is valid for decode.
- id_pc  out  ADDR_W  head pc; all zeros when id_valid=0.
- id_inst  out  INST_W  head instruction; all zeros when id_valid=0 (bubble).
- id_ready  in  1  decode consumes the head this cycle (0 = decode stalled).
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, active-high): rd_ptr=0, wr_ptr=0, count=0.
  - Outputs during and after reset: id_valid=0, id_pc=0, id_inst=0, if_ready=1.
  - Storage contents are don't-care.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & id_ready & ~flush.
- if_ready = (count != DEPTH). This is registered-state only; there is no same-cycle pass-through when full, even if a pop occurs.
- id_valid = (count != 0).
- id_pc and id_inst are driven combinationally from the head entry and AND-gated with id_valid.
- Latency: an entry pushed on edge N appears at the ID outputs after edge N, i.e. in cycle N+1. There is no IF-to-ID bypass.
- Push only: write mem[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count where both are enabled; at count=DEPTH push is blocked by if_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally; no explicit wrap compare.
- Full (count=DEPTH): if_ready=0, and if_valid is ignored.
- Empty (count=0): id_valid=0, a bubble is output, and id_ready is ignored.
- Flush has the highest priority: on the next edge rd_ptr=wr_ptr=0 and count=0.
  - A push or pop in the same cycle is discarded.
  - id_valid=0 from the next cycle onward.
- Flush while empty: no effect beyond re-zeroing the pointers.
- Reset asserted mid-operation clears state immediately (asynchronously), regardless of push, pop or flush.
- No internal state machine beyond pointer and count registers. Occupancy moves between the conditions EMPTY (count=0), PARTIAL and FULL (count=DEPTH) purely via push and pop, and flush always returns to EMPTY.
- The queue never overflows or underflows. Asserting if_valid while if_ready=0, or id_ready while id_valid=0, is not an error and changes no state.

Decomposition:
- Shared define file carries RstEnable (1'b1), ZeroWord, InstAddrBus and InstBus widths; ADDR_W and INST_W defaults are taken from them.
- One natural sub-module, if_id_queue_mem: DEPTH x (ADDR_W+INST_W) register array with synchronous write port (we, waddr, wdata) and combinational read port (raddr, rdata).
- The pointer, count and flush logic stays in if_id_queue.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then release with if_valid=0 -> id_valid=0, id_pc=0, id_inst=0, if_ready=1, count=0.
- Single transfer: push pc=0x100, inst=0x34011234 at edge N with id_ready=1 -> id_valid=1 showing those values in cycle N+1; popped at edge N+1; count returns to 0.
- Fill to full: id_ready=0, push pc=0x0,0x4,0x8,0xC -> count=4, if_ready=0; a fifth offer of pc=0x10 is ignored; id_pc stays 0x0.
- Full with simultaneous pop: at count=4 raise id_ready=1 -> outputs pop in order 0x0,0x4,0x8,0xC; if_ready reasserts the cycle after the first pop; wrap-around push pc=0x10 emerges after 0xC.
- Steady streaming: if_valid=1 and id_ready=1 for 20 cycles with incrementing pc from 0x200 -> count stays 1 after the first cycle; every pc appears exactly once, in order.
- Flush: with count=3, assert flush together with if_valid (pc=0x40) and id_ready -> next cycle count=0 and id_valid=0; 0x40 never appears; a following push of pc=0x80 appears one cycle later.
